// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg -- shared types for the programmable clock-enable generator.
//   state_t : generator FSM states
//   cfg_t   : one complete waveform configuration (period, high time, oneshot)
//   CFG_W   : storage width of the configuration fields; the generator
//             parameter W must not exceed it.
package clk_ctrl_pkg;

  localparam int CFG_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
    logic             oneshot;
  } cfg_t;

  // Configuration loaded at reset: 50 % duty, free running.
  function automatic cfg_t default_cfg(input int unsigned p);
    cfg_t c;
    c.period  = CFG_W'(p);
    c.high    = CFG_W'(p >> 1);
    c.oneshot = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/clk_ctrl_cfg.sv
// clk_ctrl_cfg -- configuration front end for clk_ctrl.
// Validates offered configurations, holds one in a shadow register and hands
// it to the active configuration when the generator opens a transfer window.
// Ports:
//   clk, rst               clock, async active-high reset
//   cfg_valid/cfg_ready    offer handshake; ready drops while a shadow is pending
//   cfg_period/high/oneshot offered configuration
//   cfg_err                one-cycle pulse after a rejected offer
//   xfer_window            generator is at a point where a swap is safe
//   active                 configuration currently driving the generator
module clk_ctrl_cfg
  import clk_ctrl_pkg::*;
#(
  parameter int          W          = 32,
  parameter int unsigned DEF_PERIOD = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_high,
  input  logic         cfg_oneshot,
  output logic         cfg_err,
  input  logic         xfer_window,
  output cfg_t         active
);

  logic pending;
  cfg_t shadow;
  logic accept;
  logic bad;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && !pending;
  assign bad       = (cfg_period < W'(2)) || (cfg_high == '0) || (cfg_high >= cfg_period);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      shadow  <= default_cfg(DEF_PERIOD);
      active  <= default_cfg(DEF_PERIOD);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && bad;
      // Acceptance needs !pending and transfer needs pending, so they never collide.
      if (accept && !bad) begin
        shadow.period  <= CFG_W'(cfg_period);
        shadow.high    <= CFG_W'(cfg_high);
        shadow.oneshot <= cfg_oneshot;
        pending        <= 1'b1;
      end else if (pending && xfer_window) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// clk_ctrl -- programmable clock-enable generator.
// Produces gen high for the first H cycles of every P-cycle period and a
// tick on the last cycle of each period. New configurations only take effect
// at a period boundary (or straight away while idle).
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_valid/ready/period/high/oneshot  configuration handshake
//   cfg_err                    one-cycle pulse on a rejected configuration
//   start, stop                begin generation / stop at end of current period
//   gen, tick, busy            waveform, end-of-period pulse, not idle
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int          W          = 32,
  parameter int unsigned DEF_PERIOD = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_high,
  input  logic         cfg_oneshot,
  input  logic         start,
  input  logic         stop,
  output logic         gen,
  output logic         tick,
  output logic         busy,
  output logic         cfg_err
);

  state_t       state;
  logic [W-1:0] cnt;
  cfg_t         active;
  logic [W-1:0] per;
  logic [W-1:0] hi;
  logic         last;

  assign per  = W'(active.period);
  assign hi   = W'(active.high);
  assign last = (cnt == per - W'(1));

  // Outputs decode only registered state, so reset clears them at once.
  assign busy = (state != IDLE);
  assign gen  = busy && (cnt < hi);
  assign tick = busy && last;

  clk_ctrl_cfg #(
    .W          (W),
    .DEF_PERIOD (DEF_PERIOD)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_oneshot (cfg_oneshot),
    .cfg_err     (cfg_err),
    .xfer_window ((state == IDLE) || last),
    .active      (active)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start && !stop) state <= RUN;
        end
        RUN: begin
          if (last) begin
            cnt <= '0;
            // A stop seen on the final cycle already has its period finished.
            if (active.oneshot || stop) state <= IDLE;
          end else begin
            cnt <= cnt + W'(1);
            if (stop) state <= STOPPING;
          end
        end
        STOPPING: begin
          if (last) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ctrl.sv
// tb_clk_ctrl -- directed, scoreboard-based bench for clk_ctrl.
// Each expected cycle is pushed as {gen, tick, busy, cfg_ready, cfg_err}
// and popped when the DUT is sampled on the falling edge.
module tb_clk_ctrl;

  localparam int W = 32;

  localparam logic [4:0] IDLE_V = 5'b00010;
  localparam logic [4:0] PEND_V = 5'b00000;
  localparam logic [4:0] ERR_V  = 5'b00011;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_oneshot = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         gen;
  logic         tick;
  logic         busy;
  logic         cfg_err;

  logic [4:0] obs;
  logic [4:0] sb[$];
  int checks = 0;
  int errors = 0;

  assign obs = {gen, tick, busy, cfg_ready, cfg_err};

  clk_ctrl #(
    .W          (W),
    .DEF_PERIOD (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .gen         (gen),
    .tick        (tick),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [4:0] v);
    sb.push_back(v);
  endtask

  // One full period of the waveform as the specification describes it.
  task automatic push_period(input int p, input int h, input logic r);
    for (int c = 0; c < p; c++)
      sb.push_back({(c < h), (c == p - 1), 1'b1, r, 1'b0});
  endtask

  task automatic compare_now(input string tag);
    logic [4:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %b but scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_now(tag);
    end
  endtask

  task automatic set_cfg(input int p, input int h, input logic os);
    cfg_valid   = 1'b1;
    cfg_period  = W'(p);
    cfg_high    = W'(h);
    cfg_oneshot = os;
  endtask

  initial begin
    // Reset state
    push(IDLE_V);
    run("reset", 1);
    rst = 1'b0;

    // Default configuration P=10, H=5, stopped late in the period
    start = 1'b1;
    push_period(10, 5, 1'b1);
    run("default", 1);
    start = 1'b0;
    run("default", 7);
    stop = 1'b1;
    run("default_stop", 1);
    stop = 1'b0;
    run("default_stop", 1);
    push(IDLE_V);
    run("default_idle", 1);

    // P=4, H=2: configure in IDLE, then two periods
    set_cfg(4, 2, 1'b0);
    push(PEND_V);
    run("cfg4_pending", 1);
    cfg_valid = 1'b0;
    push(IDLE_V);
    run("cfg4_applied", 1);
    start = 1'b1;
    push_period(4, 2, 1'b1);
    push_period(4, 2, 1'b1);
    run("p4", 1);
    start = 1'b0;
    run("p4", 7);

    // Stop at cnt=1: period completes, then IDLE
    push_period(4, 2, 1'b1);
    run("stop_cnt1", 2);
    stop = 1'b1;
    run("stop_cnt1", 1);
    stop = 1'b0;
    run("stop_cnt1", 1);
    push(IDLE_V);
    run("stop_idle", 1);

    // Reconfigure mid-period to P=6, H=3: takes effect at the boundary
    start = 1'b1;
    push(5'b10110);
    push(5'b10110);
    run("midcfg", 1);
    start = 1'b0;
    run("midcfg", 1);
    set_cfg(6, 3, 1'b0);
    push(5'b00100);
    push(5'b01100);
    run("midcfg_pending", 1);
    cfg_valid = 1'b0;
    run("midcfg_pending", 1);
    push_period(6, 3, 1'b1);
    run("p6", 3);
    stop = 1'b1;
    run("p6", 1);
    stop = 1'b0;
    run("p6", 2);
    push(IDLE_V);
    run("p6_idle", 1);

    // Rejected configurations: P<2, then H>=P
    set_cfg(1, 1, 1'b0);
    push(ERR_V);
    run("rej_p1", 1);
    cfg_valid = 1'b0;
    push(IDLE_V);
    run("rej_p1_clear", 1);
    set_cfg(5, 5, 1'b0);
    push(ERR_V);
    run("rej_h5", 1);
    cfg_valid = 1'b0;
    push(IDLE_V);
    run("rej_h5_clear", 1);
    start = 1'b1;
    push_period(6, 3, 1'b1);
    run("after_rej", 1);
    start = 1'b0;
    run("after_rej", 2);
    stop = 1'b1;
    run("after_rej", 1);
    stop = 1'b0;
    run("after_rej", 2);
    push(IDLE_V);
    run("after_rej_idle", 1);

    // Oneshot P=3, H=1, start coinciding with the IDLE transfer
    set_cfg(3, 1, 1'b1);
    push(PEND_V);
    run("os_pending", 1);
    cfg_valid = 1'b0;
    start = 1'b1;
    push_period(3, 1, 1'b1);
    run("oneshot", 1);
    start = 1'b0;
    run("oneshot", 2);
    push(IDLE_V);
    push(IDLE_V);
    run("oneshot_idle", 2);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    push(IDLE_V);
    push(IDLE_V);
    run("start_stop", 2);
    start = 1'b0;
    stop  = 1'b0;

    // Async reset at cnt=2 with a pending shadow
    set_cfg(4, 3, 1'b0);
    push(PEND_V);
    run("pre_rst_cfg", 1);
    cfg_valid = 1'b0;
    push(IDLE_V);
    run("pre_rst_cfg", 1);
    start = 1'b1;
    push(5'b10110);
    run("pre_rst", 1);
    start = 1'b0;
    push(5'b10110);
    run("pre_rst", 1);
    set_cfg(8, 4, 1'b0);
    push(5'b10100);
    run("pre_rst_pending", 1);
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    push(IDLE_V);
    compare_now("rst_async");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    push_period(10, 5, 1'b1);
    run("post_rst", 1);
    start = 1'b0;
    run("post_rst", 7);
    stop = 1'b1;
    run("post_rst", 1);
    stop = 1'b0;
    run("post_rst", 1);
    push(IDLE_V);
    run("post_rst_idle", 1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_ctrl.md
CLK_CTRL -- requirements
Module: clk_ctrl

Interface
REQ-001 SHALL have parameter W, default 32: counter and configuration width.
REQ-002 SHALL have parameter DEF_PERIOD, default 50000000: period in clk cycles after reset.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  new configuration offered.
REQ-006 SHALL have port cfg_ready  output  1  shadow register free, configuration accepted when cfg_valid && cfg_ready.
REQ-007 SHALL have port cfg_period  input  W  requested period P in cycles.
REQ-008 SHALL have port cfg_high  input  W  requested high time H in cycles.
REQ-009 SHALL have port cfg_oneshot  input  1  run exactly one period, then stop.
REQ-010 SHALL have port start  input  1  begin generation.
REQ-011 SHALL have port stop  input  1  stop at end of current period.
REQ-012 SHALL have port gen  output  1  generated clock-enable waveform.
REQ-013 SHALL have port tick  output  1  one-cycle end-of-period pulse.
REQ-014 SHALL have port busy  output  1  state != IDLE.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and STOPPING; cnt counts 0..P-1 using the active configuration (P, H, oneshot).
REQ-017 SHALL, in IDLE with start=1 and stop=0, go to RUN with cnt=0 on the next edge; start SHALL be ignored outside IDLE.
REQ-018 SHALL, in RUN, increment cnt each cycle and wrap cnt from P-1 to 0.
REQ-019 SHALL drive gen = busy && (cnt < H), combinationally from registered state and cnt, with no glitch path from inputs.
REQ-020 SHALL drive tick=1 exactly in cycles where busy && cnt==P-1.
REQ-021 SHALL, on stop=1 in RUN, go to STOPPING; STOPPING SHALL finish the period, then enter IDLE with cnt=0 at cnt==P-1.
REQ-022 SHALL give stop priority when start and stop are both high in IDLE: remain IDLE; stop in IDLE SHALL be ignored.
REQ-023 SHALL, with active oneshot=1, go from RUN to IDLE at the first cnt==P-1; tick SHALL still pulse.
REQ-024 SHALL reject a configuration with P<2, H==0 or H>=P: pulse cfg_err the next cycle, leave the shadow untouched, keep cfg_ready=1.
REQ-025 SHALL capture a valid accepted configuration into a shadow register and set pending; cfg_ready = !pending.
REQ-026 SHALL transfer the shadow to the active configuration and clear pending: in IDLE on the cycle after acceptance; in RUN/STOPPING only on the edge where cnt==P-1, so a period is never truncated or stretched.
REQ-027 SHALL apply the shadow if a boundary transfer coincides with a stop or oneshot exit into IDLE.
REQ-028 SHALL, when start arrives in IDLE in the same cycle the shadow transfers, begin the first period with the new configuration.

Reset
REQ-029 SHALL on rst: state=IDLE, cnt=0, P=DEF_PERIOD, H=DEF_PERIOD>>1, oneshot=0, pending=0; outputs gen=0, tick=0, busy=0, cfg_ready=1, cfg_err=0.
REQ-030 SHALL, when rst asserts mid-period, force gen and tick low immediately and discard any pending shadow.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN, STOPPING) and a cfg struct (period, high, oneshot) in package clk_ctrl_pkg.
REQ-032 SHALL implement validation, shadow register and handshake in sub-module clk_ctrl_cfg; clk_ctrl holds the FSM and counter.

Verification
REQ-033 SHALL verify: configure P=4, H=2, then start -> gen pattern 1,1,0,0 repeating; tick high each cycle where cnt=3.
REQ-034 SHALL verify: stop asserted at cnt=1 -> period completes, tick at cnt=3, IDLE next cycle, gen=0, busy=0.
REQ-035 SHALL verify: in RUN with P=4, configure P=6, H=3 at cnt=1 -> cfg_ready=0 until boundary; next period 1,1,1,0,0,0.
REQ-036 SHALL verify: configure P=1, then H=5 with P=5 -> both rejected, one-cycle cfg_err each, active configuration unchanged.
REQ-037 SHALL verify: oneshot=1, P=3, H=1, start -> gen 1,0,0, single tick, IDLE; start and stop together in IDLE -> stays IDLE.
REQ-038 SHALL verify: rst asserted asynchronously at cnt=2 -> gen=0 immediately, defaults restored, pending shadow cleared.
